// File: rtl/edge_to_flip_pkg.sv
// -----------------------------------------------------------------------------
// edge_to_flip_pkg
// Shared definitions for the multi-channel edge-to-toggle converter:
//   - edge_mode_t : 2-bit per-channel edge selection
//   - EDGE_*      : encodings of edge_mode_t
//   - edge_accept : maps (mode, rise, fall) to "this edge is accepted"
// -----------------------------------------------------------------------------
package edge_to_flip_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t EDGE_RISE = 2'b00;
    localparam edge_mode_t EDGE_FALL = 2'b01;
    localparam edge_mode_t EDGE_BOTH = 2'b10;
    localparam edge_mode_t EDGE_NONE = 2'b11;

    // Mode decode shared by every channel. EDGE_NONE never accepts anything.
    function automatic logic edge_accept(input edge_mode_t mode,
                                         input logic       rise,
                                         input logic       fall);
        logic acc;
        acc = 1'b0;
        case (mode)
            EDGE_RISE: acc = rise;
            EDGE_FALL: acc = fall;
            EDGE_BOTH: acc = rise | fall;
            default:   acc = 1'b0;
        endcase
        return acc;
    endfunction

endpackage : edge_to_flip_pkg

// File: rtl/edge_to_flip_ch.sv
// -----------------------------------------------------------------------------
// edge_to_flip_ch
// One channel of the edge-to-toggle converter: optional input synchroniser,
// previous-sample register, edge-mode decode, toggle output, one-cycle edge
// pulse and a saturating event counter.
//
// Ports
//   clk      in   clock
//   rstn     in   synchronous active-low reset
//   data_i   in   raw event input
//   en_i     in   channel enable (gates acceptance, not sampling)
//   mode_i   in   edge selection (rise / fall / both / none)
//   clr_i    in   counter clear, level-sampled every cycle
//   flip_o   out  toggles once per accepted edge (registered)
//   pulse_o  out  high for the cycle following an accepted edge (registered)
//   acc_o    out  combinational accepted-edge strobe, for the top-level OR
//   cnt_o    out  saturating count of accepted edges (registered)
// -----------------------------------------------------------------------------
module edge_to_flip_ch
    import edge_to_flip_pkg::*;
#(
    parameter int SYNC_STAGES = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 data_i,
    input  logic                 en_i,
    input  edge_mode_t           mode_i,
    input  logic                 clr_i,
    output logic                 flip_o,
    output logic                 pulse_o,
    output logic                 acc_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                 d_s;
    logic                 prev_q;
    logic                 rise;
    logic                 fall;
    logic                 acc;
    logic                 flip_q,  flip_d;
    logic                 pulse_q;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

    // ------------------------------------------------------------------
    // Input synchroniser. With zero stages the input feeds edge detection
    // directly, which keeps the legacy single-cycle latency.
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign d_s = data_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // NOTE: sequential state is always assigned with <= so every flop
            // samples the pre-edge value of its neighbour; with = the chain
            // would collapse into a single stage.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= data_i;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign d_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection. prev tracks the input even while the channel is
    // disabled, so enabling a channel whose input is already high does not
    // manufacture an edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_s;
        end
    end

    assign rise = d_s & ~prev_q;
    assign fall = ~d_s & prev_q;
    assign acc  = en_i & edge_accept(mode_i, rise, fall);

    // ------------------------------------------------------------------
    // Next-state logic for the toggle and the counter.
    // Counter priority: clear-with-edge restarts at 1, plain clear goes to 0,
    // an edge increments unless saturated, otherwise hold.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        flip_d = flip_q;
        cnt_d  = cnt_q;

        if (acc) begin
            flip_d = ~flip_q;
        end

        if (clr_i && acc) begin
            cnt_d = CNT_WIDTH'(1);
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (acc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            flip_q  <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            flip_q  <= flip_d;
            pulse_q <= acc;
            cnt_q   <= cnt_d;
        end
    end

    assign flip_o  = flip_q;
    assign pulse_o = pulse_q;
    assign acc_o   = acc;
    assign cnt_o   = cnt_q;

endmodule : edge_to_flip_ch

// File: rtl/edge_to_flip_multi.sv
// -----------------------------------------------------------------------------
// edge_to_flip_multi
// Multi-channel edge-to-toggle converter. Each channel turns an edge on its
// input into a toggle on its flip output so events survive crossing to slower
// or unrelated consumers. This level only fans the packed vectors out to the
// channels, packs the results back and registers the OR of accepted edges.
//
// Ports
//   clk          in   clock
//   rstn         in   synchronous active-low reset
//   data_in      in   [NUM_CH]            event inputs, bit i = channel i
//   ch_en        in   [NUM_CH]            per-channel enable
//   edge_mode    in   [2*NUM_CH]          channel i at [2i+1:2i]
//                                         (00 rise, 01 fall, 10 both, 11 none)
//   cnt_clr      in   [NUM_CH]            per-channel counter clear
//   flip_output  out  [NUM_CH]            per-channel toggle (registered)
//   edge_pulse   out  [NUM_CH]            one-cycle pulse per accepted edge
//   any_edge     out  1                   registered OR of accepted edges
//   event_cnt    out  [CNT_WIDTH*NUM_CH]  channel i at
//                                         [CNT_WIDTH*(i+1)-1:CNT_WIDTH*i]
// -----------------------------------------------------------------------------
module edge_to_flip_multi
    import edge_to_flip_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_CH-1:0]           data_in,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic [2*NUM_CH-1:0]         edge_mode,
    input  logic [NUM_CH-1:0]           cnt_clr,
    output logic [NUM_CH-1:0]           flip_output,
    output logic [NUM_CH-1:0]           edge_pulse,
    output logic                        any_edge,
    output logic [CNT_WIDTH*NUM_CH-1:0] event_cnt
);

    logic [NUM_CH-1:0] acc;
    logic              any_edge_q;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            edge_to_flip_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .CNT_WIDTH   (CNT_WIDTH)
            ) u_ch (
                .clk     (clk),
                .rstn    (rstn),
                .data_i  (data_in[i]),
                .en_i    (ch_en[i]),
                .mode_i  (edge_mode_t'(edge_mode[2*i +: 2])),
                .clr_i   (cnt_clr[i]),
                .flip_o  (flip_output[i]),
                .pulse_o (edge_pulse[i]),
                .acc_o   (acc[i]),
                .cnt_o   (event_cnt[CNT_WIDTH*i +: CNT_WIDTH])
            );
        end
    endgenerate

    // Registered alongside edge_pulse so any_edge equals |edge_pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            any_edge_q <= 1'b0;
        end else begin
            any_edge_q <= |acc;
        end
    end

    assign any_edge = any_edge_q;

endmodule : edge_to_flip_multi

// File: tb/tb_edge_to_flip_multi.sv
// -----------------------------------------------------------------------------
// tb_edge_to_flip_multi
// Two instances share one stimulus stream: dut_a with no synchroniser and
// 16-bit counters, dut_b with a two-stage synchroniser and 3-bit counters.
// A reference model computes expected outputs from the recorded input history:
// the filtered input at edge k is the input recorded SYNC_STAGES edges
// earlier (or 0 if a reset fell inside that window), edges are decided from
// the filtered values at edges k and k-1, and flips/counters follow the
// accept and counter rules with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_edge_to_flip_multi;

    localparam int NCH   = 4;
    localparam int CW_A  = 16;
    localparam int CW_B  = 3;
    localparam int HIST  = 4096;

    logic                clk;
    logic                rstn;
    logic [NCH-1:0]      data_in;
    logic [NCH-1:0]      ch_en;
    logic [2*NCH-1:0]    edge_mode;
    logic [NCH-1:0]      cnt_clr;

    logic [NCH-1:0]      flip_a, pulse_a, flip_b, pulse_b;
    logic                any_a, any_b;
    logic [CW_A*NCH-1:0] cnt_a;
    logic [CW_B*NCH-1:0] cnt_b;

    int checks   = 0;
    int failures = 0;

    edge_to_flip_multi #(.NUM_CH(NCH), .SYNC_STAGES(0), .CNT_WIDTH(CW_A)) u_dut_a (
        .clk         (clk),
        .rstn        (rstn),
        .data_in     (data_in),
        .ch_en       (ch_en),
        .edge_mode   (edge_mode),
        .cnt_clr     (cnt_clr),
        .flip_output (flip_a),
        .edge_pulse  (pulse_a),
        .any_edge    (any_a),
        .event_cnt   (cnt_a)
    );

    edge_to_flip_multi #(.NUM_CH(NCH), .SYNC_STAGES(2), .CNT_WIDTH(CW_B)) u_dut_b (
        .clk         (clk),
        .rstn        (rstn),
        .data_in     (data_in),
        .ch_en       (ch_en),
        .edge_mode   (edge_mode),
        .cnt_clr     (cnt_clr),
        .flip_output (flip_b),
        .edge_pulse  (pulse_b),
        .any_edge    (any_b),
        .event_cnt   (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    logic [NCH-1:0] samp [HIST];
    int             edge_k   = 0;
    int             last_rst = -1;
    logic [NCH-1:0] m_flip  [2];
    logic [NCH-1:0] m_pulse [2];
    logic           m_any   [2];
    int             m_cnt   [2][NCH];

    function automatic int stages_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int max_of(input int d);
        return (d == 0) ? (1 << CW_A) - 1 : (1 << CW_B) - 1;
    endfunction

    // Filtered input of instance d as seen at edge j.
    function automatic logic [NCH-1:0] filt(input int d, input int j);
        int s;
        s = stages_of(d);
        if (s == 0) return samp[j];
        if (j - s > last_rst) return samp[j - s];
        return '0;
    endfunction

    always @(posedge clk) begin : model
        logic [NCH-1:0] now_v, prv_v, acc_v;
        logic           r, f, a;
        samp[edge_k] = data_in;
        if (!rstn) begin
            last_rst = edge_k;
            for (int d = 0; d < 2; d++) begin
                m_flip[d]  = '0;
                m_pulse[d] = '0;
                m_any[d]   = 1'b0;
                for (int i = 0; i < NCH; i++) m_cnt[d][i] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                now_v = filt(d, edge_k);
                prv_v = (edge_k - 1 > last_rst) ? filt(d, edge_k - 1) : '0;
                acc_v = '0;
                for (int i = 0; i < NCH; i++) begin
                    r = now_v[i] && !prv_v[i];
                    f = !now_v[i] && prv_v[i];
                    case (edge_mode[2*i +: 2])
                        2'b00:   a = r;
                        2'b01:   a = f;
                        2'b10:   a = r || f;
                        default: a = 1'b0;
                    endcase
                    a = a && ch_en[i];
                    acc_v[i] = a;
                    if (a) m_flip[d][i] = ~m_flip[d][i];
                    if (cnt_clr[i] && a)                    m_cnt[d][i] = 1;
                    else if (cnt_clr[i])                    m_cnt[d][i] = 0;
                    else if (a && m_cnt[d][i] < max_of(d))  m_cnt[d][i] = m_cnt[d][i] + 1;
                end
                m_pulse[d] = acc_v;
                m_any[d]   = |acc_v;
            end
        end
        edge_k++;
    end

    // ---------------------------------------------------------------- checks
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (edge %0d)", tag, obs, exp, edge_k);
        end
    endtask

    task automatic check_all();
        logic [CW_A*NCH-1:0] ea;
        logic [CW_B*NCH-1:0] eb;
        for (int i = 0; i < NCH; i++) begin
            ea[CW_A*i +: CW_A] = CW_A'(m_cnt[0][i]);
            eb[CW_B*i +: CW_B] = CW_B'(m_cnt[1][i]);
        end
        chk("a_flip",  64'(flip_a),  64'(m_flip[0]));
        chk("a_pulse", 64'(pulse_a), 64'(m_pulse[0]));
        chk("a_any",   64'(any_a),   64'(m_any[0]));
        chk("a_cnt",   64'(cnt_a),   64'(ea));
        chk("b_flip",  64'(flip_b),  64'(m_flip[1]));
        chk("b_pulse", 64'(pulse_b), 64'(m_pulse[1]));
        chk("b_any",   64'(any_b),   64'(m_any[1]));
        chk("b_cnt",   64'(cnt_b),   64'(eb));
    endtask

    // Advance one clock; outputs are compared at the following negedge, after
    // which the caller drives the next inputs.
    task automatic tick(input int n = 1);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin : stim
        rstn      = 1'b0;
        data_in   = '0;
        ch_en     = '0;
        edge_mode = '0;
        cnt_clr   = '0;
        tick(3);
        chk("rst_flip_a", 64'(flip_a), 64'd0);
        chk("rst_cnt_b",  64'(cnt_b),  64'd0);

        // Legacy single-channel behaviour on channel 0, mode rise.
        rstn  = 1'b1;
        ch_en = 4'b0001;
        tick(9);
        data_in = 4'b0001;
        tick();
        chk("legacy_flip",  64'(flip_a[0]),  64'd1);
        chk("legacy_pulse", 64'(pulse_a[0]), 64'd1);
        tick(2);
        chk("legacy_pulse_gone", 64'(pulse_a[0]), 64'd0);
        data_in = 4'b0000;
        tick(3);
        chk("legacy_fall_hold", 64'(flip_a[0]),          64'd1);
        chk("legacy_cnt",       64'(cnt_a[CW_A-1:0]),    64'd1);
        chk("sync_latency_b",   64'(flip_b[0]),          64'd1);

        // Mode sweep: ch0..3 = rise, fall, both, none.
        do_reset();
        ch_en     = 4'b1111;
        edge_mode = {2'b11, 2'b10, 2'b01, 2'b00};
        tick(3);
        data_in = 4'b1111;
        tick(4);
        data_in = 4'b0000;
        tick(4);
        chk("sweep_flip_a", 64'(flip_a), 64'b0011);
        chk("sweep_flip_b", 64'(flip_b), 64'b0011);
        chk("sweep_cnt_a",  64'(cnt_a),  {16'd0, 16'd0, 16'd2, 16'd1, 16'd1});

        // Enable gating: rise while disabled, enable while high.
        do_reset();
        edge_mode = '0;
        ch_en     = 4'b0000;
        tick(2);
        data_in = 4'b0001;
        tick(3);
        ch_en = 4'b0001;
        tick(4);
        chk("gate_flip", 64'(flip_a[0]),       64'd0);
        chk("gate_cnt",  64'(cnt_a[CW_A-1:0]), 64'd0);
        data_in = 4'b0000;
        tick(3);
        data_in = 4'b0001;
        tick(4);
        chk("gate_flip_after", 64'(flip_a[0]), 64'd1);

        // Mode both, input toggling every cycle.
        edge_mode = {4{2'b10}};
        ch_en     = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            data_in = ~data_in;
            tick();
        end
        tick(3);

        // Saturation: nine rising edges on channel 0.
        do_reset();
        edge_mode = '0;
        data_in   = '0;
        tick();
        for (int i = 0; i < 9; i++) begin
            data_in = 4'b0001;
            tick();
            data_in = 4'b0000;
            tick();
        end
        tick(3);
        chk("sat_cnt_b", 64'(cnt_b[CW_B-1:0]), 64'd7);
        chk("sat_cnt_a", 64'(cnt_a[CW_A-1:0]), 64'd9);
        // Clear together with an edge restarts at 1, clear alone goes to 0.
        data_in = 4'b0001;
        cnt_clr = 4'b0001;
        tick();
        chk("clr_edge_a", 64'(cnt_a[CW_A-1:0]), 64'd1);
        cnt_clr = 4'b0000;
        tick(3);
        cnt_clr = 4'b0001;
        tick();
        chk("clr_only_a", 64'(cnt_a[CW_A-1:0]), 64'd0);
        chk("clr_only_b", 64'(cnt_b[CW_B-1:0]), 64'd0);
        cnt_clr = 4'b0000;

        // Input held high across reset: one rising edge after release.
        data_in = 4'b1111;
        rstn    = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick();
        chk("rst_high_flip_a", 64'(flip_a), 64'hf);
        tick(3);
        chk("rst_high_flip_b", 64'(flip_b), 64'hf);

        // Reset in the middle of a burst.
        edge_mode = {4{2'b10}};
        for (int i = 0; i < 5; i++) begin
            data_in = 4'($urandom);
            tick();
        end
        data_in = ~data_in;
        rstn    = 1'b0;
        tick();
        chk("mid_rst_flip",  64'(flip_a | flip_b),   64'd0);
        chk("mid_rst_pulse", 64'(pulse_a | pulse_b), 64'd0);
        chk("mid_rst_cnt",   64'(cnt_a),             64'd0);
        rstn = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            data_in = 4'($urandom);
            ch_en   = 4'($urandom) | 4'($urandom);
            cnt_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 15) == 0) edge_mode = 8'($urandom);
            rstn = ($urandom_range(0, 99) != 0);
            tick();
        end
        rstn = 1'b1;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_edge_to_flip_multi
